// File: rtl/mc_main_ctrl.sv
// Multi-cycle main control FSM for the MIPS-subset CPU: sequences fetch, decode,
// execute, memory and writeback, and stalls on the memory ready handshake.
module mc_main_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [5:0]       op_i,
   input  logic             zero_i,
   input  logic             mem_ready_i,
   output logic             mem_req_o,
   output logic             mem_we_o,
   output logic             iord_o,
   output logic             ir_write_o,
   output logic             pc_write_o,
   output logic [1:0]       pc_src_o,
   output logic             alu_src_a_o,
   output logic [1:0]       alu_src_b_o,
   output logic [2:0]       alu_op_o,
   output logic             reg_write_o,
   output logic             reg_dst_o,
   output logic             mem_to_reg_o,
   output logic             illegal_o,
   output logic [2:0]       state_o,
   output logic [CNT_W-1:0] retired_o
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_BRANCH = 3'd5,
      S_JUMP   = 3'd6
   } state_e;

   localparam logic [5:0] OP_R     = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTIU = 6'b001011;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [2:0] ALU_R     = 3'd0;
   localparam logic [2:0] ALU_ADDI  = 3'd1;
   localparam logic [2:0] ALU_SLTIU = 3'd2;
   localparam logic [2:0] ALU_BEQ   = 3'd3;
   localparam logic [2:0] ALU_LUI   = 3'd4;
   localparam logic [2:0] ALU_ORI   = 3'd5;
   localparam logic [2:0] ALU_BNE   = 3'd6;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic             retire_s;
   logic             mem_req_s, mem_we_s, iord_s, ir_write_s, pc_write_s;
   logic [1:0]       pc_src_s, alu_src_b_s;
   logic             alu_src_a_s;
   logic [2:0]       alu_op_s;
   logic             reg_write_s, reg_dst_s, mem_to_reg_s, illegal_s;

   // Next-state, retire strobe and datapath controls for the current state
   always_comb begin
      state_d      = state_q;
      retire_s     = 1'b0;
      mem_req_s    = 1'b0;
      mem_we_s     = 1'b0;
      iord_s       = 1'b0;
      ir_write_s   = 1'b0;
      pc_write_s   = 1'b0;
      pc_src_s     = 2'd0;
      alu_src_a_s  = 1'b0;
      alu_src_b_s  = 2'd0;
      alu_op_s     = ALU_R;
      reg_write_s  = 1'b0;
      reg_dst_s    = 1'b0;
      mem_to_reg_s = 1'b0;
      illegal_s    = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_req_s   = 1'b1;
            alu_src_b_s = 2'd1;
            alu_op_s    = ALU_ADDI;
            if (mem_ready_i) begin
               ir_write_s = 1'b1;
               pc_write_s = 1'b1;
               state_d    = S_DECODE;
            end else begin
               state_d    = S_FETCH;
            end
         end
         S_DECODE: begin
            alu_src_b_s = 2'd3;
            alu_op_s    = ALU_ADDI;
            case (op_i)
               OP_R, OP_ADDI, OP_SLTIU, OP_ORI, OP_LUI, OP_LW, OP_SW: state_d = S_EXEC;
               OP_BEQ, OP_BNE: state_d = S_BRANCH;
               OP_J:           state_d = S_JUMP;
               default: begin
                  illegal_s = 1'b1;
                  state_d   = S_FETCH;
               end
            endcase
         end
         S_EXEC: begin
            alu_src_a_s = 1'b1;
            alu_src_b_s = (op_i == OP_R) ? 2'd0 : 2'd2;
            case (op_i)
               OP_R:                  alu_op_s = ALU_R;
               OP_ADDI, OP_LW, OP_SW: alu_op_s = ALU_ADDI;
               OP_SLTIU:              alu_op_s = ALU_SLTIU;
               OP_ORI:                alu_op_s = ALU_ORI;
               OP_LUI:                alu_op_s = ALU_LUI;
               default:               alu_op_s = ALU_R;
            endcase
            state_d = ((op_i == OP_LW) || (op_i == OP_SW)) ? S_MEM : S_WB;
         end
         S_MEM: begin
            mem_req_s = 1'b1;
            iord_s    = 1'b1;
            mem_we_s  = (op_i == OP_SW);
            if (!mem_ready_i) begin
               state_d = S_MEM;
            end else if (op_i == OP_SW) begin
               state_d  = S_FETCH;
               retire_s = 1'b1;
            end else begin
               state_d = S_WB;
            end
         end
         S_WB: begin
            reg_write_s  = 1'b1;
            reg_dst_s    = (op_i == OP_R);
            mem_to_reg_s = (op_i == OP_LW);
            state_d      = S_FETCH;
            retire_s     = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a_s = 1'b1;
            pc_src_s    = 2'd1;
            if (op_i == OP_BNE) begin
               alu_op_s   = ALU_BNE;
               pc_write_s = ~zero_i;
            end else begin
               alu_op_s   = ALU_BEQ;
               pc_write_s = zero_i;
            end
            state_d  = S_FETCH;
            retire_s = 1'b1;
         end
         S_JUMP: begin
            pc_write_s = 1'b1;
            pc_src_s   = 2'd2;
            state_d    = S_FETCH;
            retire_s   = 1'b1;
         end
         default: state_d = S_FETCH;
      endcase
      retired_d = retire_s ? (retired_q + CNT_W'(1)) : retired_q;
   end

   // Outputs are squashed while reset is asserted so nothing strobes mid-abort
   always_comb begin
      if (!rst_i) begin
         mem_req_o    = 1'b0;
         mem_we_o     = 1'b0;
         iord_o       = 1'b0;
         ir_write_o   = 1'b0;
         pc_write_o   = 1'b0;
         pc_src_o     = 2'd0;
         alu_src_a_o  = 1'b0;
         alu_src_b_o  = 2'd0;
         alu_op_o     = 3'd0;
         reg_write_o  = 1'b0;
         reg_dst_o    = 1'b0;
         mem_to_reg_o = 1'b0;
         illegal_o    = 1'b0;
      end else begin
         mem_req_o    = mem_req_s;
         mem_we_o     = mem_we_s;
         iord_o       = iord_s;
         ir_write_o   = ir_write_s;
         pc_write_o   = pc_write_s;
         pc_src_o     = pc_src_s;
         alu_src_a_o  = alu_src_a_s;
         alu_src_b_o  = alu_src_b_s;
         alu_op_o     = alu_op_s;
         reg_write_o  = reg_write_s;
         reg_dst_o    = reg_dst_s;
         mem_to_reg_o = mem_to_reg_s;
         illegal_o    = illegal_s;
      end
   end

   // State and retired-instruction counter
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q   <= S_FETCH;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         retired_q <= retired_d;
      end
   end

   assign state_o   = state_q;
   assign retired_o = retired_q;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Self-checking bench for mc_main_ctrl: directed instruction table, hand-written
// reset/wrap sequences and random instruction streams against an instruction-level model.
module tb_mc_main_ctrl;

   localparam logic [5:0] OP_R     = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTIU = 6'b001011;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_J     = 6'b000010;

   typedef struct packed {
      logic [2:0] st;
      logic       req, we, iord, irw, pcw;
      logic [1:0] pcs;
      logic       sa;
      logic [1:0] sb;
      logic [2:0] aop;
      logic       rw, rd, m2r, ill;
   } exp_t;

   typedef struct {
      logic       ready;
      logic       zero;
      logic [5:0] op;
      exp_t       e;
   } cyc_t;

   typedef struct {
      logic [5:0] op;
      logic       zero;
      int         fw;
      int         mw;
      int         lat;
   } vec_t;

   logic clk, rst_n, zero, ready;
   logic [5:0] op;
   logic mem_req, mem_we, iord, ir_write, pc_write, alu_src_a, reg_write, reg_dst, mem_to_reg, illegal;
   logic [1:0] pc_src, alu_src_b;
   logic [2:0] alu_op, state;
   logic [31:0] retired;
   logic m4_req, m4_we, m4_iord, m4_irw, m4_pcw, m4_sa, m4_rw, m4_rd, m4_m2r, m4_ill;
   logic [1:0] m4_pcs, m4_sb;
   logic [2:0] m4_aop, m4_st;
   logic [3:0] retired4;

   int total = 0;
   int bad = 0;
   int model_ret = 0;
   cyc_t plan[$];
   exp_t got_s, got4_s;

   mc_main_ctrl #(.CNT_W(32)) dut (
      .clk_i(clk), .rst_i(rst_n), .op_i(op), .zero_i(zero), .mem_ready_i(ready),
      .mem_req_o(mem_req), .mem_we_o(mem_we), .iord_o(iord), .ir_write_o(ir_write),
      .pc_write_o(pc_write), .pc_src_o(pc_src), .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b),
      .alu_op_o(alu_op), .reg_write_o(reg_write), .reg_dst_o(reg_dst), .mem_to_reg_o(mem_to_reg),
      .illegal_o(illegal), .state_o(state), .retired_o(retired)
   );

   mc_main_ctrl #(.CNT_W(4)) dut4 (
      .clk_i(clk), .rst_i(rst_n), .op_i(op), .zero_i(zero), .mem_ready_i(ready),
      .mem_req_o(m4_req), .mem_we_o(m4_we), .iord_o(m4_iord), .ir_write_o(m4_irw),
      .pc_write_o(m4_pcw), .pc_src_o(m4_pcs), .alu_src_a_o(m4_sa), .alu_src_b_o(m4_sb),
      .alu_op_o(m4_aop), .reg_write_o(m4_rw), .reg_dst_o(m4_rd), .mem_to_reg_o(m4_m2r),
      .illegal_o(m4_ill), .state_o(m4_st), .retired_o(retired4)
   );

   assign got_s  = {state, mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a,
                    alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, illegal};
   assign got4_s = {m4_st, m4_req, m4_we, m4_iord, m4_irw, m4_pcw, m4_pcs, m4_sa,
                    m4_sb, m4_aop, m4_rw, m4_rd, m4_m2r, m4_ill};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", name, act, req);
      end
   endtask

   function automatic exp_t blank(input logic [2:0] st);
      exp_t e;
      e    = '0;
      e.st = st;
      return e;
   endfunction

   function automatic void push(input logic rdy, input logic z, input logic [5:0] o, input exp_t e);
      cyc_t c;
      c.ready = rdy;
      c.zero  = z;
      c.op    = o;
      c.e     = e;
      plan.push_back(c);
   endfunction

   function automatic logic [2:0] alu_for(input logic [5:0] o);
      case (o)
         OP_ADDI, OP_LW, OP_SW: return 3'd1;
         OP_SLTIU:              return 3'd2;
         OP_LUI:                return 3'd4;
         OP_ORI:                return 3'd5;
         default:               return 3'd0;
      endcase
   endfunction

   // Expands one instruction into its expected cycle-by-cycle behaviour; returns 1 if it retires
   function automatic logic build(input logic [5:0] o, input logic z, input int fw, input int mw);
      exp_t e;
      logic is_alu, is_ls, is_br;
      is_alu = (o == OP_R) || (o == OP_ADDI) || (o == OP_SLTIU) || (o == OP_ORI) || (o == OP_LUI);
      is_ls  = (o == OP_LW) || (o == OP_SW);
      is_br  = (o == OP_BEQ) || (o == OP_BNE);
      e = blank(3'd0); e.req = 1'b1; e.sb = 2'd1; e.aop = 3'd1;
      for (int i = 0; i < fw; i++) push(1'b0, 1'($urandom), 6'($urandom), e);
      e.irw = 1'b1; e.pcw = 1'b1;
      push(1'b1, 1'($urandom), 6'($urandom), e);
      e = blank(3'd1); e.sb = 2'd3; e.aop = 3'd1;
      if (!(is_alu || is_ls || is_br || o == OP_J)) begin
         e.ill = 1'b1;
         push(1'($urandom), 1'($urandom), o, e);
         return 1'b0;
      end
      push(1'($urandom), 1'($urandom), o, e);
      if (is_alu || is_ls) begin
         e = blank(3'd2); e.sa = 1'b1; e.sb = (o == OP_R) ? 2'd0 : 2'd2; e.aop = alu_for(o);
         push(1'($urandom), 1'($urandom), o, e);
         if (is_ls) begin
            e = blank(3'd3); e.req = 1'b1; e.iord = 1'b1; e.we = (o == OP_SW);
            for (int i = 0; i < mw; i++) push(1'b0, 1'($urandom), o, e);
            push(1'b1, 1'($urandom), o, e);
         end
         if (o != OP_SW) begin
            e = blank(3'd4); e.rw = 1'b1; e.rd = (o == OP_R); e.m2r = (o == OP_LW);
            push(1'($urandom), 1'($urandom), o, e);
         end
      end else if (is_br) begin
         e = blank(3'd5); e.sa = 1'b1; e.pcs = 2'd1;
         e.aop = (o == OP_BEQ) ? 3'd3 : 3'd6;
         e.pcw = (o == OP_BEQ) ? z : ~z;
         push(1'($urandom), z, o, e);
      end else begin
         e = blank(3'd6); e.pcw = 1'b1; e.pcs = 2'd2;
         push(1'($urandom), 1'($urandom), o, e);
      end
      return 1'b1;
   endfunction

   // Runs one instruction from FETCH, checking every cycle; lat = cycles until back in FETCH
   task automatic run_instr(input logic [5:0] o, input logic z, input int fw, input int mw, output int lat);
      cyc_t c;
      logic legal, seen;
      int n;
      legal = build(o, z, fw, mw);
      lat = -1; seen = 1'b0; n = 0;
      while (plan.size() > 0) begin
         c = plan.pop_front();
         ready = c.ready; zero = c.zero; op = c.op;
         #2;
         check($sformatf("cycle op=%b n=%0d", o, n), 64'(got_s), 64'(c.e));
         check($sformatf("cycle4 op=%b n=%0d", o, n), 64'(got4_s), 64'(c.e));
         @(posedge clk); #1;
         n++;
         if (state != 3'd0) seen = 1'b1;
         else if (seen && lat < 0) lat = n;
      end
      if (legal) model_ret++;
      check($sformatf("retired op=%b", o), 64'(retired), 64'(32'(model_ret)));
      check($sformatf("retired4 op=%b", o), 64'(retired4), 64'(model_ret % 16));
   endtask

   vec_t vt[14];
   logic [5:0] legal_ops[10];

   initial begin
      int lat;
      vt[0]  = '{OP_R,     1'b0, 0, 0, 4};
      vt[1]  = '{OP_LW,    1'b0, 0, 2, 7};
      vt[2]  = '{OP_BEQ,   1'b1, 0, 0, 3};
      vt[3]  = '{OP_BNE,   1'b1, 0, 0, 3};
      vt[4]  = '{6'b111111, 1'b0, 0, 0, 2};
      vt[5]  = '{OP_SW,    1'b0, 1, 0, 5};
      vt[6]  = '{OP_ORI,   1'b0, 0, 0, 4};
      vt[7]  = '{OP_J,     1'b0, 0, 0, 3};
      vt[8]  = '{OP_BNE,   1'b0, 0, 0, 3};
      vt[9]  = '{OP_BEQ,   1'b0, 2, 0, 5};
      vt[10] = '{OP_LUI,   1'b0, 0, 0, 4};
      vt[11] = '{OP_SLTIU, 1'b1, 0, 0, 4};
      vt[12] = '{OP_ADDI,  1'b0, 0, 0, 4};
      vt[13] = '{OP_SW,    1'b0, 0, 1, 5};
      legal_ops = '{OP_R, OP_ADDI, OP_SLTIU, OP_ORI, OP_LUI, OP_BEQ, OP_BNE, OP_LW, OP_SW, OP_J};

      rst_n = 1'b0; ready = 1'b1; op = OP_R; zero = 1'b0;
      #2;
      check("reset outputs", 64'(got_s), 64'd0);
      check("reset retired", 64'(retired), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      for (int i = 0; i < 14; i++) begin
         run_instr(vt[i].op, vt[i].zero, vt[i].fw, vt[i].mw, lat);
         check($sformatf("latency vec %0d", i), 64'(lat), 64'(vt[i].lat));
      end

      // Abort an SW while it is stalled in MEM
      ready = 1'b1; op = OP_SW; zero = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      ready = 1'b0;
      #2;
      check("sw mem state", 64'(state), 64'd3);
      check("sw mem req", 64'(mem_req), 64'd1);
      rst_n = 1'b0;
      #1;
      check("abort outputs", 64'(got_s), 64'd0);
      check("abort retired", 64'(retired), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      check("restart state", 64'(state), 64'd0);
      check("restart retired", 64'(retired), 64'd0);
      model_ret = 0;
      @(posedge clk); #1;

      // Sixteen jumps wrap the 4-bit counter back to zero
      for (int i = 0; i < 16; i++) begin
         run_instr(OP_J, 1'($urandom), 0, 0, lat);
         check("jump latency", 64'(lat), 64'd3);
      end
      check("wrap retired4", 64'(retired4), 64'd0);
      check("wrap retired32", 64'(retired), 64'd16);

      for (int i = 0; i < 150; i++) begin
         logic [5:0] o;
         if ($urandom_range(0, 7) == 0) o = 6'($urandom);
         else o = legal_ops[$urandom_range(0, 9)];
         run_instr(o, 1'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), lat);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
